// File: rtl/prio_grant_encoder.sv
// Registered N-input priority encoder/arbiter that holds its grant until ack.
// Define PRIO_GRANT_RR_EN to select round-robin priority instead of fixed lowest-index-first.
module prio_grant_encoder #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic                 ack,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] code,
    output logic                 valid
);

    localparam int CODE_W = $clog2(N);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    state_e              state_q;
    logic [N-1:0]        gnt_q;
    logic [CODE_W-1:0]   code_q;
    logic                valid_q;
    logic [CODE_W-1:0]   win_d;
    logic [N-1:0]        gnt_d;

`ifdef PRIO_GRANT_RR_EN
    logic [CODE_W-1:0]   ptr_q;
    logic [CODE_W-1:0]   ptr_d;

    // First set request found scanning upward from p, wrapping past N-1 to 0.
    function automatic logic [CODE_W-1:0] pick_rr(input logic [N-1:0] r, input logic [CODE_W-1:0] p);
        logic [CODE_W-1:0] idx;
        logic              found;
        int                pos;
        idx   = {CODE_W{1'b0}};
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            pos = (int'(p) + k) % N;
            if (r[pos] && !found) begin
                idx   = CODE_W'(pos);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    // Winner search and the pointer value to load when the current grant is acked.
    always_comb begin
        win_d = pick_rr(req, ptr_q);
        gnt_d = {{(N-1){1'b0}}, 1'b1} << win_d;
        if (code_q == CODE_W'(N - 1)) begin
            ptr_d = {CODE_W{1'b0}};
        end else begin
            ptr_d = code_q + CODE_W'(1);
        end
    end
`else
    function automatic logic [CODE_W-1:0] pick_fixed(input logic [N-1:0] r);
        logic [CODE_W-1:0] idx;
        idx = {CODE_W{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            if (r[i]) begin
                idx = CODE_W'(i);
            end
        end
        return idx;
    endfunction

    // Winner search: lowest set index has priority.
    always_comb begin
        win_d = pick_fixed(req);
        gnt_d = {{(N-1){1'b0}}, 1'b1} << win_d;
    end
`endif

    // Grant FSM with registered outputs; a release always passes through one IDLE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= {N{1'b0}};
            code_q  <= {CODE_W{1'b0}};
            valid_q <= 1'b0;
`ifdef PRIO_GRANT_RR_EN
            ptr_q   <= {CODE_W{1'b0}};
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        state_q <= ST_GRANT;
                        gnt_q   <= gnt_d;
                        code_q  <= win_d;
                        valid_q <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        gnt_q   <= {N{1'b0}};
                        code_q  <= {CODE_W{1'b0}};
                        valid_q <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (ack) begin
                        state_q <= ST_IDLE;
                        gnt_q   <= {N{1'b0}};
                        code_q  <= {CODE_W{1'b0}};
                        valid_q <= 1'b0;
`ifdef PRIO_GRANT_RR_EN
                        ptr_q   <= ptr_d;
`endif
                    end else begin
                        state_q <= ST_GRANT;
                        gnt_q   <= gnt_q;
                        code_q  <= code_q;
                        valid_q <= valid_q;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= {N{1'b0}};
                    code_q  <= {CODE_W{1'b0}};
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign gnt   = gnt_q;
    assign code  = code_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_prio_grant_encoder.sv
// Self-checking bench for prio_grant_encoder: reset, directed vector table, random vs. model, N=5 build.
module tb_prio_grant_encoder;

    localparam int N = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       ack;
    logic [3:0] gnt;
    logic [1:0] code;
    logic       valid;

    logic [4:0] req5;
    logic       ack5;
    logic [4:0] gnt5;
    logic [2:0] code5;
    logic       valid5;

    int checks;
    int failures;

    // Reference model state: plain integers, not the RTL's encoding.
    int m_valid;
    int m_code;
    int m_ptr;

    typedef struct {
        logic [3:0] req;
        logic       ack;
        logic       valid;
        logic [1:0] code;
        logic [3:0] gnt;
    } vec_t;

    vec_t vecs[$];

    prio_grant_encoder #(.N(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .ack(ack),
        .gnt(gnt), .code(code), .valid(valid)
    );

    prio_grant_encoder #(.N(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .req(req5), .ack(ack5),
        .gnt(gnt5), .code(code5), .valid(valid5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    task automatic model_update(input logic [3:0] r, input logic a);
        if (m_valid == 0) begin
            if (r != 4'b0000) begin
                m_valid = 1;
                m_code  = pick(r, m_ptr);
            end
        end else if (a) begin
`ifdef PRIO_GRANT_RR_EN
            m_ptr = (m_code + 1) % N;
`endif
            m_valid = 0;
            m_code  = 0;
        end
    endtask

    task automatic step(input logic [3:0] r, input logic a);
        req = r;
        ack = a;
        @(posedge clk);
        model_update(r, a);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_valid"}, {31'd0, valid}, m_valid);
        chk({tag, "_code"},  {30'd0, code},  m_code);
        chk({tag, "_gnt"},   {28'd0, gnt},   (m_valid != 0) ? (32'd1 << m_code) : 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        m_valid  = 0;
        m_code   = 0;
        m_ptr    = 0;
        rst_n    = 1'b0;
        req      = 4'b0000;
        ack      = 1'b0;
        req5     = 5'b00000;
        ack5     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", {31'd0, valid}, 32'd0);
        chk("reset_gnt",   {28'd0, gnt},   32'd0);
        rst_n = 1'b1;

        // Asynchronous reset in the middle of a grant to agent 2.
        step(4'b0100, 1'b0);
        chk("pre_reset_gnt", {28'd0, gnt}, 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, valid}, 32'd0);
        chk("async_rst_gnt",   {28'd0, gnt},   32'd0);
        chk("async_rst_code",  {30'd0, code},  32'd0);
        req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        m_valid = 0; m_code = 0; m_ptr = 0;
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
        chk("post_rst_valid", {31'd0, valid}, 32'd0);
        chk("post_rst_gnt",   {28'd0, gnt},   32'd0);

`ifdef PRIO_GRANT_RR_EN
        vecs.push_back('{4'b1111, 1'b0, 1'b1, 2'd0, 4'b0001});
        vecs.push_back('{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000});
        vecs.push_back('{4'b1111, 1'b0, 1'b1, 2'd1, 4'b0010});
        vecs.push_back('{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000});
        vecs.push_back('{4'b1111, 1'b0, 1'b1, 2'd2, 4'b0100});
        vecs.push_back('{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000});
        vecs.push_back('{4'b1111, 1'b0, 1'b1, 2'd3, 4'b1000});
        vecs.push_back('{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000});
        vecs.push_back('{4'b1111, 1'b0, 1'b1, 2'd0, 4'b0001});
        vecs.push_back('{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000});
        vecs.push_back('{4'b0001, 1'b0, 1'b1, 2'd0, 4'b0001});
        vecs.push_back('{4'b0001, 1'b1, 1'b0, 2'd0, 4'b0000});
        vecs.push_back('{4'b0101, 1'b0, 1'b1, 2'd2, 4'b0100});
        vecs.push_back('{4'b0001, 1'b0, 1'b1, 2'd2, 4'b0100});
        vecs.push_back('{4'b0001, 1'b1, 1'b0, 2'd0, 4'b0000});
        vecs.push_back('{4'b0011, 1'b0, 1'b1, 2'd0, 4'b0001});
        vecs.push_back('{4'b0011, 1'b1, 1'b0, 2'd0, 4'b0000});
`else
        vecs.push_back('{4'b1010, 1'b0, 1'b1, 2'd1, 4'b0010});
        vecs.push_back('{4'b1010, 1'b1, 1'b0, 2'd0, 4'b0000});
        vecs.push_back('{4'b1000, 1'b0, 1'b1, 2'd3, 4'b1000});
        vecs.push_back('{4'b1000, 1'b1, 1'b0, 2'd0, 4'b0000});
        vecs.push_back('{4'b0100, 1'b0, 1'b1, 2'd2, 4'b0100});
        vecs.push_back('{4'b0001, 1'b0, 1'b1, 2'd2, 4'b0100});
        vecs.push_back('{4'b0000, 1'b0, 1'b1, 2'd2, 4'b0100});
        vecs.push_back('{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000});
        vecs.push_back('{4'b1111, 1'b0, 1'b1, 2'd0, 4'b0001});
        vecs.push_back('{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000});
        vecs.push_back('{4'b1111, 1'b1, 1'b1, 2'd0, 4'b0001});
        vecs.push_back('{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000});
        vecs.push_back('{4'b1111, 1'b1, 1'b1, 2'd0, 4'b0001});
        vecs.push_back('{4'b1111, 1'b0, 1'b1, 2'd0, 4'b0001});
        vecs.push_back('{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000});
        vecs.push_back('{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000});
        vecs.push_back('{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000});
        vecs.push_back('{4'b0100, 1'b0, 1'b1, 2'd2, 4'b0100});
        vecs.push_back('{4'b0100, 1'b1, 1'b0, 2'd0, 4'b0000});
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].req, vecs[i].ack);
            chk($sformatf("vec%0d_valid", i), {31'd0, valid}, {31'd0, vecs[i].valid});
            chk($sformatf("vec%0d_code", i),  {30'd0, code},  {30'd0, vecs[i].code});
            chk($sformatf("vec%0d_gnt", i),   {28'd0, gnt},   {28'd0, vecs[i].gnt});
        end

        // Random traffic against the behavioural model; ack biased so grants last a few cycles.
        for (int i = 0; i < 300; i++) begin
            logic [3:0] r;
            logic       a;
            r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) r = 4'b0000;
            a = ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0;
            step(r, a);
            check_model($sformatf("rnd%0d", i));
        end

        // N=5 instance: top agent and 3-bit code.
        req5 = 5'b10000;
        ack5 = 1'b0;
        @(posedge clk);
        #1;
        chk("n5_valid", {31'd0, valid5}, 32'd1);
        chk("n5_code",  {29'd0, code5},  32'd4);
        chk("n5_gnt",   {27'd0, gnt5},   32'h10);
        ack5 = 1'b1;
        @(posedge clk);
        #1;
        chk("n5_rel_valid", {31'd0, valid5}, 32'd0);
        chk("n5_rel_gnt",   {27'd0, gnt5},   32'd0);
        req5 = 5'b00110;
        ack5 = 1'b0;
        @(posedge clk);
        #1;
        chk("n5_next_code", {29'd0, code5}, 32'd1);
        chk("n5_next_gnt",  {27'd0, gnt5},  32'h02);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
